lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store unit between execute stage and word-indexed data_mem (addr/wd/we/rd, one 32-bit word per index).
//  Turns byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
//  Does read-modify-write for SB/SH, since data_mem has no byte enables.
//  Does load alignment with sign/zero extension, and flags misaligned or illegal requests.
// PARAMETERS
//  MEM_AW    32  width of mem_addr (word index)
//  ERR_MISAL  1  1: misaligned request -> error response, no memory access; 0: low address bits forced aligned
// PORTS
//  clk         in   1   single clock, all state updates on posedge
//  rst_n       in   1   asynchronous active-low reset
//  req_valid   in   1   request present
//  req_ready   out  1   1 only in IDLE; handshake = req_valid & req_ready at posedge
//  req_store   in   1   1 = store, 0 = load
//  req_funct3  in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (RISC-V encoding)
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data; low byte/half used for SB/SH
//  resp_valid  out  1   one-cycle pulse, response complete
//  resp_rdata  out  32  load result, aligned and extended; 0 for stores and errors
//  resp_err    out  1   valid with resp_valid: misaligned or illegal funct3
//  mem_addr    out  MEM_AW  word index = req_addr[31:2], zero-extended
//  mem_wd      out  32  write data to data_mem
//  mem_we      out  1   write enable to data_mem
//  mem_rd      in   32  combinational read data from data_mem at mem_addr
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_we=0; mem_addr=0; mem_wd=0.
//  mem_we is a pure decode of state (WR or MERGE), so it drops as soon as rst_n falls.
//  FSM states: IDLE, RD, WR, MERGE, RESP, ERR. Request fields are captured at the handshake.
//  IDLE -> ERR   : illegal funct3 (011/110/111, or 100/101 with store), or misaligned with ERR_MISAL=1.
//                  Misaligned means: H with addr[0]!=0, or W with addr[1:0]!=0.
//  IDLE -> RD    : any load, or SB/SH.
//  IDLE -> WR    : SW.
//  RD    : mem_we=0. Load: sample mem_rd, shift right by 8*addr[1:0], extend, then go to RESP.
//          SB/SH: capture mem_rd as the old word, then go to MERGE.
//  MERGE : mem_we=1, mem_wd = old word with the addressed byte/half replaced, then RESP.
//          Byte lane = addr[1:0]; half lane = addr[1].
//  WR    : mem_we=1, mem_wd=req_wdata, then RESP.
//  RESP  : resp_valid=1 with resp_rdata; ERR: resp_valid=1, resp_err=1. Both return to IDLE.
//  mem_addr is held stable from the cycle after the handshake through RESP/ERR.
//  Latency, counted from handshake cycle N:
//    resp_valid at N+1 for errors; N+2 for loads and SW; N+3 for SB/SH.
//  Throughput: next request accepted in the cycle after RESP/ERR (req_ready high again).
//  req_valid while req_ready=0 is ignored, not queued. Upstream must hold the request.
//  Extension: B/H sign-extend bit 7/15; BU/HU zero-fill.
//  With ERR_MISAL=0: H ignores addr[0], W ignores addr[1:0].
//  Reset mid-operation: any in-flight access is abandoned. No partial write beyond the current cycle. No response is issued.
// TESTING
//  1 SW addr 0x0 data AAAABBBB; LW addr 0x0 -> mem_we high exactly 1 cycle;
//    LW resp_rdata=AAAABBBB at N+2, resp_err=0.
//  2 After 1: SB addr 0x1 data 0x000000CC -> RD then MERGE; word 0 becomes AAAACCBB; resp_valid at N+3.
//  3 After 2: LB 0x1 -> FFFFFFCC; LBU 0x1 -> 000000CC; LHU 0x2 -> 0000AAAA; LH 0x2 -> FFFFAAAA.
//  4 SH addr 0x5 / LW addr 0x6 (ERR_MISAL=1) -> resp_err=1 at N+1; mem_we never asserts; memory unchanged.
//  5 funct3=011 load, and funct3=100 store -> resp_err=1, resp_rdata=0, no memory access.
//  6 Drop rst_n during MERGE of SB 0x4 -> mem_we falls immediately; no resp_valid;
//    req_ready=1 after release; next LW 0x4 returns a consistent word.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: byte-addressed RISC-V loads/stores onto a word-indexed data memory
// without byte enables (read-modify-write for SB/SH, aligned/extended loads).
module lsu_mem_ctrl #(
  parameter int MEM_AW    = 32,
  parameter bit ERR_MISAL = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  output logic              mem_we,
  input  logic [31:0]       mem_rd
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR, S_MERGE, S_RESP, S_ERR
  } state_e;

  state_e      state_q, state_d;
  logic        store_q, store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;   // load result, or old word for SB/SH

  logic        handshake, illegal, misal, req_err;
  logic [31:0] eff_addr, shifted, load_val, lane_mask, merged;
  logic [4:0]  lane_sh;

  assign handshake = req_valid && (state_q == S_IDLE);

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    illegal  = (req_funct3[1:0] == 2'b11) ||
               (req_funct3[2] && (req_store || req_funct3[1]));
    misal    = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
               ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_err  = illegal || (ERR_MISAL && misal);
    eff_addr = req_addr;
    if (!ERR_MISAL) begin
      if (req_funct3[1:0] == 2'b01)      eff_addr[0]   = 1'b0;
      else if (req_funct3[1:0] == 2'b10) eff_addr[1:0] = 2'b00;
    end
  end

  always_comb begin
    shifted = mem_rd >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'h0, shifted[7:0]};
      3'b101:  load_val = {16'h0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // Half stores select the lane with addr[1] only; byte stores use addr[1:0].
  always_comb begin
    lane_sh   = funct3_q[0] ? {addr_q[1], 4'b0000} : {addr_q[1:0], 3'b000};
    lane_mask = (funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << lane_sh;
    merged    = (data_q & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
  end

  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    data_d   = data_q;
    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          store_d  = req_store;
          funct3_d = req_funct3;
          addr_d   = eff_addr;
          wdata_d  = req_wdata;
          if (req_err)                               state_d = S_ERR;
          else if (req_store && req_funct3 == 3'b010) state_d = S_WR;
          else                                       state_d = S_RD;
        end
      end
      S_RD: begin
        data_d  = store_q ? mem_rd : load_val;
        state_d = store_q ? S_MERGE : S_RESP;
      end
      S_WR, S_MERGE:  state_d = S_RESP;
      S_RESP, S_ERR:  state_d = S_IDLE;
      default:        state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      store_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      data_q   <= 32'h0;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      data_q   <= data_d;
    end
  end

  // Outputs decode the state directly so a falling rst_n kills mem_we at once.
  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP) || (state_q == S_ERR);
  assign resp_err   = (state_q == S_ERR);
  assign resp_rdata = (state_q == S_RESP && !store_q) ? data_q : 32'h0;
  assign mem_we     = (state_q == S_WR) || (state_q == S_MERGE);
  assign mem_wd     = (state_q == S_WR)    ? wdata_q :
                      (state_q == S_MERGE) ? merged  : 32'h0;
  assign mem_addr   = MEM_AW'({2'b00, addr_q[31:2]});

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized bench for lsu_mem_ctrl: byte-level reference memory model, latency,
// write-count and response checks, plus the directed scenarios including mid-merge reset.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        mem_we;

  lsu_mem_ctrl #(.MEM_AW(32), .ERR_MISAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Environment data memory (16 words) and independent reference copy.
  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];
  int          we_cnt;
  int          n_checks = 0;
  int          n_fail   = 0;

  assign mem_rd = mem[mem_addr[3:0]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[3:0]] <= mem_wd;
      we_cnt = we_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] word, input int off,
                                           input int size, input bit uns);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < size; i++)
      v |= ((word >> (8 * (off + i))) & 32'hFF) << (8 * i);
    if (!uns && size < 4 && v[8*size-1])
      v |= ~((32'h1 << (8 * size)) - 32'h1);
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] word, input int off,
                                            input int size, input logic [31:0] wd);
    logic [31:0] w = word;
    for (int i = 0; i < size; i++)
      w = (w & ~(32'hFF << (8 * (off + i)))) | (((wd >> (8 * i)) & 32'hFF) << (8 * (off + i)));
    return w;
  endfunction

  task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] got_rdata);
    int size, lat, exp_lat, exp_we, idx;
    bit uns, illegal, err, done;
    logic [31:0] exp_rd;
    size    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    uns     = f3[2];
    illegal = (f3[1:0] == 2'b11) || (f3[2] && (st || f3[1]));
    err     = illegal || ((a % size) != 0);
    idx     = int'(a[5:2]);
    exp_lat = err ? 1 : (st && size < 4) ? 3 : 2;
    exp_we  = (st && !err) ? 1 : 0;
    exp_rd  = (!st && !err) ? ref_load(ref_mem[idx], int'(a % 4), size, uns) : 32'h0;

    @(negedge clk);
    check("ready_before_req", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    we_cnt = 0;
    @(posedge clk);
    lat = 0; done = 0; got_rdata = 32'hX;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
      // Busy-time requests with junk fields must be ignored.
      req_valid  = 1'($urandom);
      req_store  = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      check("mem_addr_hold", mem_addr, a >> 2);
      if (resp_valid) begin
        done = 1;
        got_rdata = resp_rdata;
        check("resp_err", {31'h0, resp_err}, {31'h0, err});
        check("resp_rdata", resp_rdata, exp_rd);
      end
    end
    req_valid = 1'b0;
    check("latency", lat, exp_lat);
    check("we_cycles", we_cnt, exp_we);
    if (st && !err) ref_mem[idx] = ref_store(ref_mem[idx], int'(a % 4), size, wd);
    check("mem_word", mem[idx], ref_mem[idx]);
    @(negedge clk);
    check("resp_pulse", {31'h0, resp_valid}, 32'h0);
  endtask

  logic [31:0] rd;

  initial begin
    req_valid = 0; req_store = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    we_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    check("rst_ready",  {31'h0, req_ready},  32'h1);
    check("rst_rvalid", {31'h0, resp_valid}, 32'h0);
    check("rst_err",    {31'h0, resp_err},   32'h0);
    check("rst_rdata",  resp_rdata,          32'h0);
    check("rst_we",     {31'h0, mem_we},     32'h0);
    check("rst_maddr",  mem_addr,            32'h0);
    check("rst_wd",     mem_wd,              32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Scenario 1-3: SW/LW, SB merge, sub-word loads.
    do_req(1, 3'b010, 32'h0, 32'hAAAA_BBBB, rd);
    do_req(0, 3'b010, 32'h0, 32'h0, rd);
    check("t1_lw", rd, 32'hAAAA_BBBB);
    do_req(1, 3'b000, 32'h1, 32'h0000_00CC, rd);
    check("t2_word", mem[0], 32'hAAAA_CCBB);
    do_req(0, 3'b000, 32'h1, 32'h0, rd);
    check("t3_lb", rd, 32'hFFFF_FFCC);
    do_req(0, 3'b100, 32'h1, 32'h0, rd);
    check("t3_lbu", rd, 32'h0000_00CC);
    do_req(0, 3'b101, 32'h2, 32'h0, rd);
    check("t3_lhu", rd, 32'h0000_AAAA);
    do_req(0, 3'b001, 32'h2, 32'h0, rd);
    check("t3_lh", rd, 32'hFFFF_AAAA);

    // Scenario 4-5: misaligned and illegal requests.
    do_req(1, 3'b001, 32'h5, 32'h1234_5678, rd);
    do_req(0, 3'b010, 32'h6, 32'h0, rd);
    do_req(0, 3'b011, 32'h8, 32'h0, rd);
    do_req(1, 3'b100, 32'h8, 32'hDEAD_BEEF, rd);

    // Scenario 6: reset during the MERGE of SB 0x4.
    @(negedge clk);
    req_valid = 1; req_store = 1; req_funct3 = 3'b000; req_addr = 32'h4; req_wdata = 32'h5A;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    check("t6_we_merge", {31'h0, mem_we}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_we_drop", {31'h0, mem_we},     32'h0);
    check("t6_no_resp", {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_ready",   {31'h0, req_ready},  32'h1);
    check("t6_no_resp2", {31'h0, resp_valid}, 32'h0);
    check("t6_mem", mem[1], ref_mem[1]);
    do_req(0, 3'b010, 32'h4, 32'h0, rd);

    // Randomized traffic, biased toward legal encodings.
    for (int n = 0; n < 300; n++) begin
      logic [2:0] f3;
      bit st;
      st = 1'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end else begin
        f3 = 3'($urandom);
      end
      do_req(st, f3, 32'($urandom_range(0, 63)), $urandom, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
